// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types and helpers for the per-slave arbiter.
package ahb_slave_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWNED  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_type;

  // Beat count of a burst; INCR has no fixed length and reports 0.
  function automatic logic [4:0] burst_beats(input hburst_type b);
    case (b)
      SINGLE:         return 5'd1;
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin request picker: first set request at or after ptr_i, wrapping.
module ahb_rr_picker #(
  parameter int N      = 4,
  parameter int MIDX_W = $clog2(N)
) (
  input  logic [N-1:0]      req_i,
  input  logic [MIDX_W-1:0] ptr_i,
  output logic [MIDX_W-1:0] pick_o,
  output logic              found_o
);

  int idx;

  // Scan from the pointer, keep the first hit.
  always_comb begin
    pick_o  = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found_o && req_i[idx[MIDX_W-1:0]]) begin
        found_o = 1'b1;
        pick_o  = idx[MIDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin grant held across bursts and locked
// sequences, with registered address- and data-phase master indices.
import ahb_slave_arbiter_pkg::*;

module ahb_slave_arbiter #(
  parameter int SLAVE_X_MASTER_NUM = 4,
  parameter int MIDX_W             = $clog2(SLAVE_X_MASTER_NUM)
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic [SLAVE_X_MASTER_NUM-1:0] hreq,
  input  logic [SLAVE_X_MASTER_NUM-1:0] hlock,
  input  htrans_type                    htrans [SLAVE_X_MASTER_NUM],
  input  hburst_type                    hburst [SLAVE_X_MASTER_NUM],
  input  logic                          hready,
  output logic [SLAVE_X_MASTER_NUM-1:0] hgrant,
  output logic [MIDX_W-1:0]             hsel_addr,
  output logic                          addr_valid,
  output logic [MIDX_W-1:0]             hsel_data,
  output logic                          data_valid
);

  arb_state_type                 state_q, state_d;
  logic [SLAVE_X_MASTER_NUM-1:0] hgrant_q, hgrant_d;
  logic [MIDX_W-1:0]             hsel_addr_q, hsel_addr_d;
  logic                          addr_valid_q, addr_valid_d;
  logic [MIDX_W-1:0]             hsel_data_q, hsel_data_d;
  logic                          data_valid_q, data_valid_d;
  logic [MIDX_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [4:0]                    beat_cnt_q, beat_cnt_d;
  logic                          undef_len_q, undef_len_d;

  logic [MIDX_W-1:0] pick;
  logic              found;
  logic [MIDX_W-1:0] owner;
  htrans_type        own_trans;
  logic [4:0]        own_beats;
  logic              boundary;

  function automatic logic [MIDX_W-1:0] ptr_after(input logic [MIDX_W-1:0] m);
    if (int'(m) == SLAVE_X_MASTER_NUM - 1) return '0;
    return m + MIDX_W'(1);
  endfunction

  ahb_rr_picker #(
    .N      (SLAVE_X_MASTER_NUM),
    .MIDX_W (MIDX_W)
  ) u_picker (
    .req_i   (hreq),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick),
    .found_o (found)
  );

  // Next-state logic: arbitration FSM, beat tracking and data-phase index.
  always_comb begin
    state_d      = state_q;
    hgrant_d     = hgrant_q;
    hsel_addr_d  = hsel_addr_q;
    addr_valid_d = addr_valid_q;
    hsel_data_d  = hsel_data_q;
    data_valid_d = data_valid_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    undef_len_d  = undef_len_q;

    owner     = hsel_addr_q;
    own_trans = htrans[owner];
    own_beats = burst_beats(hburst[owner]);
    boundary  = hready &&
                (own_trans == HTRANS_IDLE || !hreq[owner] ||
                 (own_trans == HTRANS_NONSEQ && own_beats == 5'd1) ||
                 (own_trans == HTRANS_SEQ && beat_cnt_q == 5'd1 && !undef_len_q));

    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          hgrant_d     = SLAVE_X_MASTER_NUM'(1) << pick;
          hsel_addr_d  = pick;
          addr_valid_d = 1'b1;
          rr_ptr_d     = ptr_after(pick);
          state_d      = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        // A lock request wins over a coincident burst boundary.
        if (hready && hlock[owner]) begin
          state_d = ARB_LOCKED;
        end else if (boundary && found) begin
          hgrant_d    = SLAVE_X_MASTER_NUM'(1) << pick;
          hsel_addr_d = pick;
          rr_ptr_d    = ptr_after(pick);
        end else if (boundary) begin
          hgrant_d     = '0;
          addr_valid_d = 1'b0;
          state_d      = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (hready && !hlock[owner]) state_d = ARB_OWNED;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Beat counting only advances on accepted transfers of the owner.
    if (state_q != ARB_IDLE && hready) begin
      if (own_trans == HTRANS_NONSEQ) begin
        beat_cnt_d  = (own_beats == 5'd0) ? 5'd0 : own_beats - 5'd1;
        undef_len_d = (hburst[owner] == INCR);
      end else if (own_trans == HTRANS_SEQ) begin
        beat_cnt_d  = (beat_cnt_q == 5'd0) ? 5'd0 : beat_cnt_q - 5'd1;
      end
    end

    if (hready) begin
      hsel_data_d  = hsel_addr_q;
      data_valid_d = addr_valid_q &&
                     (own_trans == HTRANS_NONSEQ || own_trans == HTRANS_SEQ);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ARB_IDLE;
      hgrant_q     <= '0;
      hsel_addr_q  <= '0;
      addr_valid_q <= 1'b0;
      hsel_data_q  <= '0;
      data_valid_q <= 1'b0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      undef_len_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hgrant_q     <= hgrant_d;
      hsel_addr_q  <= hsel_addr_d;
      addr_valid_q <= addr_valid_d;
      hsel_data_q  <= hsel_data_d;
      data_valid_q <= data_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      undef_len_q  <= undef_len_d;
    end
  end

  assign hgrant     = hgrant_q;
  assign hsel_addr  = hsel_addr_q;
  assign addr_valid = addr_valid_q;
  assign hsel_data  = hsel_data_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with N=4 masters.
import ahb_slave_arbiter_pkg::*;

module tb_ahb_slave_arbiter;

  logic       hclk;
  logic       hreset;
  logic [3:0] hreq;
  logic [3:0] hlock;
  htrans_type htrans [4];
  hburst_type hburst [4];
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hsel_addr;
  logic       addr_valid;
  logic [1:0] hsel_data;
  logic       data_valid;

  int checks = 0;
  int errors = 0;

  ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(4)) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .hreq       (hreq),
    .hlock      (hlock),
    .htrans     (htrans),
    .hburst     (hburst),
    .hready     (hready),
    .hgrant     (hgrant),
    .hsel_addr  (hsel_addr),
    .addr_valid (addr_valid),
    .hsel_data  (hsel_data),
    .data_valid (data_valid)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    hreq   = '0;
    hlock  = '0;
    hready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      htrans[i] = HTRANS_IDLE;
      hburst[i] = SINGLE;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
  endtask

  initial begin
    hreset = 1'b1;
    idle_inputs();

    // Reset state
    do_reset();
    chk("rst_hgrant", 32'(hgrant), 32'h0);
    chk("rst_addr_valid", 32'(addr_valid), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_hsel_addr", 32'(hsel_addr), 32'h0);
    chk("rst_hsel_data", 32'(hsel_data), 32'h0);

    // Single request from M2: one-cycle grant, data phase follows NONSEQ
    hreq = 4'b0100;
    tick();
    chk("a_hgrant", 32'(hgrant), 32'h4);
    chk("a_hsel_addr", 32'(hsel_addr), 32'h2);
    chk("a_addr_valid", 32'(addr_valid), 32'h1);
    chk("a_data_valid0", 32'(data_valid), 32'h0);
    htrans[2] = HTRANS_NONSEQ;
    tick();
    chk("a_hsel_data", 32'(hsel_data), 32'h2);
    chk("a_data_valid1", 32'(data_valid), 32'h1);
    chk("a_hgrant_keep", 32'(hgrant), 32'h4);
    hreq = 4'b0000;
    htrans[2] = HTRANS_IDLE;
    tick();
    chk("a_release_hgrant", 32'(hgrant), 32'h0);
    chk("a_release_addr_valid", 32'(addr_valid), 32'h0);
    chk("a_release_data_valid", 32'(data_valid), 32'h0);

    // M0 INCR4 with M1 requesting from beat 2
    do_reset();
    hreq = 4'b0001;
    tick();
    chk("b_grant_m0", 32'(hgrant), 32'h1);
    htrans[0] = HTRANS_NONSEQ;
    hburst[0] = INCR4;
    tick();
    chk("b_beat1", 32'(hgrant), 32'h1);
    htrans[0] = HTRANS_SEQ;
    hreq = 4'b0011;
    tick();
    chk("b_beat2", 32'(hgrant), 32'h1);
    tick();
    chk("b_beat3", 32'(hgrant), 32'h1);
    tick();
    chk("b_after_beat4", 32'(hgrant), 32'h2);
    chk("b_hsel_addr", 32'(hsel_addr), 32'h1);
    chk("b_hsel_data", 32'(hsel_data), 32'h0);
    chk("b_data_valid", 32'(data_valid), 32'h1);

    // All masters request SINGLE transfers: grants rotate
    do_reset();
    hreq = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      htrans[i] = HTRANS_NONSEQ;
      hburst[i] = SINGLE;
    end
    tick();
    chk("c_rot0", 32'(hgrant), 32'h1);
    tick();
    chk("c_rot1", 32'(hgrant), 32'h2);
    tick();
    chk("c_rot2", 32'(hgrant), 32'h4);
    tick();
    chk("c_rot3", 32'(hgrant), 32'h8);
    tick();
    chk("c_rot4", 32'(hgrant), 32'h1);

    // M2 locked across two SINGLEs while M0 requests
    do_reset();
    hreq  = 4'b0100;
    hlock = 4'b0100;
    tick();
    chk("d_grant_m2", 32'(hgrant), 32'h4);
    htrans[2] = HTRANS_NONSEQ;
    hreq = 4'b0101;
    tick();
    chk("d_lock1", 32'(hgrant), 32'h4);
    tick();
    chk("d_lock2", 32'(hgrant), 32'h4);
    hlock = 4'b0000;
    hreq  = 4'b0001;
    htrans[2] = HTRANS_IDLE;
    tick();
    chk("d_unlock_hold", 32'(hgrant), 32'h4);
    tick();
    chk("d_grant_m0", 32'(hgrant), 32'h1);
    chk("d_hsel_addr", 32'(hsel_addr), 32'h0);

    // INCR8 stalled by hready=0 for three cycles while M3 requests
    do_reset();
    hreq = 4'b0001;
    tick();
    htrans[0] = HTRANS_NONSEQ;
    hburst[0] = INCR8;
    tick();
    htrans[0] = HTRANS_SEQ;
    tick();
    tick();
    hreq   = 4'b1001;
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("e_stall_hgrant", 32'(hgrant), 32'h1);
      chk("e_stall_hsel_data", 32'(hsel_data), 32'h0);
      chk("e_stall_data_valid", 32'(data_valid), 32'h1);
    end
    hready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("e_burst_hold", 32'(hgrant), 32'h1);
    end
    tick();
    chk("e_handover_m3", 32'(hgrant), 32'h8);

    // Undefined-length INCR holds until the owner goes IDLE
    do_reset();
    hreq = 4'b0011;
    tick();
    chk("f_grant_m0", 32'(hgrant), 32'h1);
    htrans[0] = HTRANS_NONSEQ;
    hburst[0] = INCR;
    tick();
    chk("f_incr_nonseq", 32'(hgrant), 32'h1);
    htrans[0] = HTRANS_SEQ;
    tick();
    tick();
    chk("f_incr_seq", 32'(hgrant), 32'h1);
    htrans[0] = HTRANS_IDLE;
    tick();
    chk("f_incr_end", 32'(hgrant), 32'h2);

    // Reset in the middle of a WRAP16 burst
    do_reset();
    hreq = 4'b0010;
    tick();
    htrans[1] = HTRANS_NONSEQ;
    hburst[1] = WRAP16;
    tick();
    htrans[1] = HTRANS_SEQ;
    tick();
    chk("g_pre_data_valid", 32'(data_valid), 32'h1);
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    chk("g_hgrant", 32'(hgrant), 32'h0);
    chk("g_addr_valid", 32'(addr_valid), 32'h0);
    chk("g_data_valid", 32'(data_valid), 32'h0);
    chk("g_hsel_addr", 32'(hsel_addr), 32'h0);
    idle_inputs();
    tick();
    chk("g_idle_hgrant", 32'(hgrant), 32'h0);
    hreq = 4'b1111;
    tick();
    chk("g_rr_ptr_cleared", 32'(hgrant), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
- Per-slave AHB arbiter. One instance sits in front of each slave port of the AHB_Gen interconnect.
- Collects the per-slave request bit from every master's address decoder and grants the slave to one master at a time (round-robin).
- Holds each grant across burst and locked-transfer boundaries.
- Produces registered address-phase and data-phase master select indices for the slave-side mux.

Parameters:
- SLAVE_X_MASTER_NUM, 4, number of masters that can address this slave (2..16).
- MIDX_W, $clog2(SLAVE_X_MASTER_NUM), width of the master index.

Ports:
- hclk  input  1  system clock. One clock, hclk; reset is synchronous and active-high.
- hreset  input  1  synchronous active-high reset.
- hreq  input  SLAVE_X_MASTER_NUM  per-master request for this slave (decoder hreq bit).
- hlock  input  SLAVE_X_MASTER_NUM  per-master locked-transfer request.
- htrans  input  SLAVE_X_MASTER_NUM x htrans_type  per-master transfer type.
- hburst  input  SLAVE_X_MASTER_NUM x hburst_type  per-master burst type.
- hready  input  1  slave-side hready (transfer accepted / data phase done).
- hgrant  output  SLAVE_X_MASTER_NUM  one-hot grant, registered.
- hsel_addr  output  MIDX_W  index of the address-phase owner.
- addr_valid  output  1  hsel_addr is meaningful (state != IDLE).
- hsel_data  output  MIDX_W  index of the data-phase owner.
- data_valid  output  1  a non-IDLE/BUSY data phase is in progress.

Behaviour:
- Reset (hreset=1 at a hclk edge) sets: state IDLE, hgrant=0, hsel_addr=0, addr_valid=0, hsel_data=0, data_valid=0, rr_ptr=0, beat_cnt=0, undef_len=0. Reset mid-burst aborts it the same way; no partial state is kept.
- Pick (combinational): first i with hreq[i]=1, scanning rr_ptr, rr_ptr+1, … modulo N.
- On every grant to m: rr_ptr <= (m+1) mod N.
- Grant latency: one cycle. A request seen in cycle t gives hgrant valid in cycle t+1.
- States:
  - IDLE: if |hreq, then hgrant <= onehot(pick), hsel_addr <= pick, go OWNED.
  - OWNED: owner o is the index held in hsel_addr.
  - LOCKED: no handover for any reason. On hready & ~hlock[o], go OWNED.
- Beat tracking in OWNED/LOCKED, only when hready=1:
  - htrans[o]=NONSEQ: beat_cnt <= beats(hburst[o])-1. beats = 1/4/8/16 for SINGLE/x4/x8/x16. undef_len <= (hburst[o]==INCR).
  - htrans[o]=SEQ: beat_cnt <= beat_cnt-1, saturating at 0.
  - BUSY or IDLE: beat_cnt unchanged.
- boundary is true when hready=1 and any of:
  - htrans[o]=IDLE;
  - hreq[o]=0;
  - NONSEQ with beats=1;
  - SEQ with beat_cnt=1 and undef_len=0.
- OWNED transitions:
  - If hready & hlock[o], go LOCKED. This takes priority over boundary in the same cycle.
  - Else if boundary and |hreq, re-arbitrate with pick and stay OWNED. Pick may re-select o if o is the only requester.
  - Else if boundary and no hreq, then hgrant <= 0, addr_valid <= 0, go IDLE.
  - Otherwise hold the grant.
- INCR (undefined length) bursts end only on IDLE or hreq[o] deassertion.
- Data phase, on hready=1: hsel_data <= hsel_addr; data_valid <= addr_valid & htrans[o] ∈ {NONSEQ, SEQ}. With hready=0, both hold.
- hgrant is always zero or one-hot. Its index always equals hsel_addr when addr_valid=1.

Decomposition:
- AHB_package holds:
  - htrans_type (existing).
  - hburst_type enum: SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16.
  - Function burst_beats(hburst_type) returning 5 bits.
  - arb_state_type enum: IDLE, OWNED, LOCKED.
- One sub-module, ahb_rr_picker: purely combinational. Takes request vector and rr_ptr; returns pick index and a found flag.

Test Plan:
- N=4, reset then hreq=4'b0100 at t0 -> hgrant=4'b0100 and hsel_addr=2 at t1; hsel_data=2 and data_valid=1 one hready cycle after the NONSEQ.
- M0 INCR4 (NONSEQ + 3 SEQ, hready=1), M1 requests from beat 2 -> hgrant stays 4'b0001 through beat 4, then 4'b0010 the cycle after the 4th beat.
- hreq=4'b1111 held, all masters issue SINGLE -> grants rotate 0,1,2,3,0 on consecutive boundaries.
- M2 holds hlock=1 across two SINGLE transfers while M0 requests -> state LOCKED, hgrant=4'b0100 until hlock drops with hready=1, then M0 is granted.
- hready=0 for 3 cycles mid INCR8 with M3 requesting -> beat_cnt, hgrant, hsel_data frozen; no handover.
- hreset=1 mid WRAP16 -> next cycle hgrant=0, addr_valid=0, data_valid=0, state IDLE.
